// File: rtl/ternary_pkg.sv
// Shared ternary definitions: trit encodings, default widths and the
// fetch state encoding used by the instruction fetcher.
package ternary_pkg;

    localparam int WORD_SIZE     = 9;
    localparam int MEM_ADDR_SIZE = 3;

    localparam logic [1:0] TRIT_NEG  = 2'b11;
    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_INV  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_ADVANCE = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch bus: PC command, memory read, branch redirect, instruction output.
// master = fetcher side, slave = environment (PC, memory, execute, consumer).
interface instruction_fetch_if #(
    parameter int WORD_SIZE     = ternary_pkg::WORD_SIZE,
    parameter int MEM_ADDR_SIZE = ternary_pkg::MEM_ADDR_SIZE
);
    logic [2*MEM_ADDR_SIZE-1:0] pc_in;
    logic                       pc_update_enable;
    logic [2*WORD_SIZE-1:0]     pc_value;
    logic                       mem_req;
    logic [2*MEM_ADDR_SIZE-1:0] mem_addr;
    logic                       mem_ready;
    logic [2*WORD_SIZE-1:0]     mem_data;
    logic                       branch_enable;
    logic [2*WORD_SIZE-1:0]     branch_offset;
    logic [2*WORD_SIZE-1:0]     instr_out;
    logic                       instr_valid;
    logic                       instr_ready;
    logic                       instr_error;

    modport master (
        input  pc_in, mem_ready, mem_data,
        input  branch_enable, branch_offset, instr_ready,
        output pc_update_enable, pc_value, mem_req, mem_addr,
        output instr_out, instr_valid, instr_error
    );

    modport slave (
        output pc_in, mem_ready, mem_data,
        output branch_enable, branch_offset, instr_ready,
        input  pc_update_enable, pc_value, mem_req, mem_addr,
        input  instr_out, instr_valid, instr_error
    );
endinterface

// File: rtl/trit_word_check.sv
// Combinational invalid-trit detector: invalid_o is high when any trit
// of word_i carries the 2'b10 code. Ports: word_i (2*N bits), invalid_o.
module trit_word_check #(
    parameter int N = ternary_pkg::WORD_SIZE
) (
    input  logic [2*N-1:0] word_i,
    output logic           invalid_o
);
    import ternary_pkg::*;

    always_comb begin
        invalid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (word_i[2*i +: 2] == TRIT_INV) begin
                invalid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/instruction_fetch.sv
// Ternary instruction fetcher: WAIT/HOLD/ADVANCE loop with branch redirect.
// Ports: clock, reset_enable (sync, active-high), bus (instruction_fetch_if.master).
// Optional macro TRIT_CHECK_EN: replaces words holding invalid trits with NOP
// and pulses instr_error; otherwise data passes raw and instr_error stays 0.
module instruction_fetch #(
    parameter int WORD_SIZE     = ternary_pkg::WORD_SIZE,
    parameter int MEM_ADDR_SIZE = ternary_pkg::MEM_ADDR_SIZE
) (
    input  logic                clock,
    input  logic                reset_enable,
    instruction_fetch_if.master bus
);
    import ternary_pkg::*;

    localparam int W2 = 2 * WORD_SIZE;
    localparam int A2 = 2 * MEM_ADDR_SIZE;

    // +1: trit 0 positive, all higher trits zero
    localparam logic [W2-1:0] PC_STEP = {{(W2-2){1'b0}}, TRIT_POS};

    fetch_state_e    state_q, state_d;
    logic            pend_q, pend_d;
    logic [W2-1:0]   off_q, off_d;
    logic [W2-1:0]   instr_q, instr_d;
    logic            err_q, err_d;
    logic            data_bad;

`ifdef TRIT_CHECK_EN
    trit_word_check #(.N(WORD_SIZE)) u_check (
        .word_i    (bus.mem_data),
        .invalid_o (data_bad)
    );
`else
    assign data_bad = 1'b0;
`endif

    always_comb begin
        state_d              = state_q;
        pend_d               = pend_q;
        off_d                = off_q;
        instr_d              = instr_q;
        err_d                = 1'b0;
        bus.mem_req          = 1'b0;
        bus.mem_addr         = '0;
        bus.instr_valid      = 1'b0;
        bus.pc_update_enable = 1'b0;
        bus.pc_value         = '0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = bus.pc_in;
                if (bus.mem_ready) begin
                    // A redirect makes this word stale: drop it.
                    if (pend_q || bus.branch_enable) begin
                        state_d = S_ADVANCE;
                    end else begin
                        state_d = S_HOLD;
                        if (data_bad) begin
                            instr_d = '0;
                            err_d   = 1'b1;
                        end else begin
                            instr_d = bus.mem_data;
                        end
                    end
                end
            end
            S_HOLD: begin
                bus.instr_valid = 1'b1;
                if (bus.instr_ready || bus.branch_enable) begin
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                bus.pc_update_enable = 1'b1;
                bus.pc_value         = pend_q ? off_q : PC_STEP;
                pend_d               = 1'b0;
                state_d              = S_WAIT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.branch_enable && state_q != S_IDLE) begin
            pend_d = 1'b1;
            off_d  = bus.branch_offset;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_enable) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            off_q   <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            off_q   <= off_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    assign bus.instr_out   = instr_q;
    assign bus.instr_error = err_q;

    // Address width is fixed by the interface; keep the local name in use.
    logic [A2-1:0] unused_addr_w;
    assign unused_addr_w = bus.pc_in;
endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed cases plus random
// stimulus against a behavioural model with an integer-valued PC.
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    instruction_fetch_if #(.WORD_SIZE(9), .MEM_ADDR_SIZE(3)) bus ();

    instruction_fetch #(.WORD_SIZE(9), .MEM_ADDR_SIZE(3)) dut (
        .clock        (clk),
        .reset_enable (rst),
        .bus          (bus)
    );

    int checks = 0;
    int errors = 0;

    // model: 0 idle, 1 waiting on memory, 2 presenting, 3 advancing
    int           ph = 0;
    bit           pend = 0;
    int           poff = 0;
    logic [17:0]  m_instr = '0;
    bit           m_err = 0;
    int           pc = 0;
    int           cur_bo = 0;

    function automatic logic [17:0] enc(input int v);
        logic [17:0] w;
        int x;
        int t;
        w = '0;
        x = v;
        for (int i = 0; i < 9; i++) begin
            t = ((x % 3) + 3) % 3;
            if (t == 1) begin
                w[2*i +: 2] = 2'b01;
                x = (x - 1) / 3;
            end else if (t == 2) begin
                w[2*i +: 2] = 2'b11;
                x = (x + 1) / 3;
            end else begin
                x = x / 3;
            end
        end
        return w;
    endfunction

    function automatic int wrap27(input int v);
        return (((v + 13) % 27) + 27) % 27 - 13;
    endfunction

    function automatic bit has_inv(input logic [17:0] w);
        bit b;
        b = 0;
        for (int i = 0; i < 9; i++) begin
            if (w[2*i +: 2] == 2'b10) b = 1;
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [17:0] act,
                       input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp,
                     $time);
        end
    endtask

    task automatic model_step();
        int nph;
        nph = ph;
        if (ph == 3) pc = wrap27(pc + (pend ? poff : 1));
        if (rst) begin
            ph = 0;
            pend = 0;
            poff = 0;
            m_instr = '0;
            m_err = 0;
        end else begin
            m_err = 0;
            case (ph)
                0: nph = 1;
                1: if (bus.mem_ready) begin
                    if (pend || bus.branch_enable) begin
                        nph = 3;
                    end else begin
                        nph = 2;
`ifdef TRIT_CHECK_EN
                        if (has_inv(bus.mem_data)) begin
                            m_instr = '0;
                            m_err = 1;
                        end else begin
                            m_instr = bus.mem_data;
                        end
`else
                        m_instr = bus.mem_data;
`endif
                    end
                end
                2: if (bus.instr_ready || bus.branch_enable) nph = 3;
                default: begin
                    nph = 1;
                    pend = 0;
                end
            endcase
            if (bus.branch_enable && ph != 0) begin
                pend = 1;
                poff = cur_bo;
            end
            ph = nph;
        end
    endtask

    task automatic compare();
        logic [17:0] e_addr;
        logic [17:0] e_val;
        e_addr = (ph == 1) ? enc(pc) : '0;
        e_val = (ph == 3) ? enc(pend ? poff : 1) : '0;
        chk("mem_req", 18'(bus.mem_req), 18'(ph == 1));
        chk("mem_addr", 18'(bus.mem_addr), 18'(e_addr[5:0]));
        chk("instr_valid", 18'(bus.instr_valid), 18'(ph == 2));
        chk("pc_update", 18'(bus.pc_update_enable), 18'(ph == 3));
        chk("pc_value", bus.pc_value, e_val);
        chk("instr_out", bus.instr_out, m_instr);
        chk("instr_error", 18'(bus.instr_error), 18'(m_err));
    endtask

    task automatic cyc(input bit r, input bit b, input int bo,
                       input bit rdy, input bit mr, input logic [17:0] d);
        @(posedge clk);
        model_step();
        @(negedge clk);
        rst = r;
        bus.branch_enable = b;
        cur_bo = bo;
        bus.branch_offset = enc(bo);
        bus.instr_ready = rdy;
        bus.mem_ready = mr;
        bus.mem_data = d;
        bus.pc_in = enc(pc)[5:0];
        #1;
        compare();
    endtask

    function automatic logic [17:0] rand_word();
        logic [17:0] w;
        int r;
        for (int i = 0; i < 9; i++) begin
            r = int'($urandom_range(0, 63));
            if (r == 0) w[2*i +: 2] = 2'b10;
            else if (r % 3 == 0) w[2*i +: 2] = 2'b00;
            else if (r % 3 == 1) w[2*i +: 2] = 2'b01;
            else w[2*i +: 2] = 2'b11;
        end
        return w;
    endfunction

    initial begin
        bus.pc_in = '0;
        bus.mem_ready = 1'b0;
        bus.mem_data = '0;
        bus.branch_enable = 1'b0;
        bus.branch_offset = '0;
        bus.instr_ready = 1'b0;

        cyc(1, 0, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, 0, '0);
        chk("rst_valid", 18'(bus.instr_valid), 18'h0);
        chk("rst_out", bus.instr_out, 18'h0);
        chk("rst_req", 18'(bus.mem_req), 18'h0);

        // basic fetch of +1 at pc 0
        cyc(0, 0, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, 0, '0);
        chk("wait_addr0", 18'(bus.mem_addr), 18'h0);
        cyc(0, 0, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, 1, 18'h00001);
        cyc(0, 0, 0, 1, 0, '0);
        chk("hold_valid", 18'(bus.instr_valid), 18'h1);
        chk("hold_out", bus.instr_out, 18'h00001);
        cyc(0, 0, 0, 0, 0, '0);
        chk("adv_pulse", 18'(bus.pc_update_enable), 18'h1);
        chk("adv_value", bus.pc_value, 18'h00001);
        cyc(0, 0, 0, 0, 1, 18'h00015);
        chk("pc1_addr", 18'(bus.mem_addr), 18'h00001);

        // stall in HOLD for five cycles
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, '0);
            chk("stall_valid", 18'(bus.instr_valid), 18'h1);
            chk("stall_out", bus.instr_out, 18'h00015);
            chk("stall_pulse", 18'(bus.pc_update_enable), 18'h0);
        end

        // flush from HOLD with offset -3
        cyc(0, 1, -3, 0, 0, '0);
        cyc(0, 0, 0, 0, 0, '0);
        chk("flush_valid", 18'(bus.instr_valid), 18'h0);
        chk("flush_pulse", 18'(bus.pc_update_enable), 18'h1);
        chk("flush_value", bus.pc_value, 18'h0000C);
        cyc(0, 0, 0, 0, 0, '0);
        chk("single_pulse", 18'(bus.pc_update_enable), 18'h0);

        // branch during WAIT discards the returning word
        cyc(0, 1, 4, 0, 0, '0);
        cyc(0, 0, 0, 0, 1, 18'h00155);
        cyc(0, 0, 0, 0, 0, '0);
        chk("wbr_valid", 18'(bus.instr_valid), 18'h0);
        chk("wbr_value", bus.pc_value, 18'h00005);

        // PC wrap: +13 then +1 reads -13
        cyc(0, 0, 0, 0, 0, '0);
        pc = 13;
        cyc(0, 0, 0, 0, 1, 18'h00001);
        chk("pc13_addr", 18'(bus.mem_addr), 18'h00015);
        cyc(0, 0, 0, 1, 0, '0);
        cyc(0, 0, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, 0, '0);
        chk("wrap_addr", 18'(bus.mem_addr), 18'h0003F);

        // invalid trit at position 4
        cyc(0, 0, 0, 0, 1, 18'h00200);
        cyc(0, 0, 0, 1, 0, '0);
`ifdef TRIT_CHECK_EN
        chk("inv_out", bus.instr_out, 18'h0);
        chk("inv_err", 18'(bus.instr_error), 18'h1);
`else
        chk("inv_out", bus.instr_out, 18'h00200);
        chk("inv_err", 18'(bus.instr_error), 18'h0);
`endif
        cyc(0, 0, 0, 0, 0, '0);
        chk("inv_err_once", 18'(bus.instr_error), 18'h0);

        // reset mid-WAIT with a late mem_ready
        cyc(1, 0, 0, 0, 1, 18'h00005);
        cyc(0, 0, 0, 0, 0, '0);
        chk("rst_wait_valid", 18'(bus.instr_valid), 18'h0);
        chk("rst_wait_req", 18'(bus.mem_req), 18'h0);

        for (int n = 0; n < 3000; n++) begin
            bit r;
            bit b;
            r = ($urandom_range(0, 63) == 0);
            b = (ph != 3) && ($urandom_range(0, 7) == 0);
            cyc(r, b, int'($urandom_range(0, 200)) - 100,
                1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                rand_word());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter WORD_SIZE, default 9, instruction and offset width in trits.
REQ-002 Parameter MEM_ADDR_SIZE, default 3, program-counter width in trits.
REQ-003 Trit encoding SHALL be 2 bits per trit: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1, 2'b10 = invalid; trit 0 in bits [1:0].
REQ-004 clock  in  1  sole clock, rising edge.
REQ-005 reset_enable  in  1  synchronous, active-high reset.
REQ-006 pc_in  in  2*MEM_ADDR_SIZE  current program-counter value.
REQ-007 pc_update_enable  out  1  one-cycle pulse commanding the PC to add pc_value.
REQ-008 pc_value  out  2*WORD_SIZE  signed ternary offset for the PC.
REQ-009 mem_req  out  1  instruction-memory read request.
REQ-010 mem_addr  out  2*MEM_ADDR_SIZE  read address.
REQ-011 mem_ready  in  1  read data valid this cycle.
REQ-012 mem_data  in  2*WORD_SIZE  read data.
REQ-013 branch_enable  in  1  one-cycle redirect pulse from execute.
REQ-014 branch_offset  in  2*WORD_SIZE  redirect offset, sampled with branch_enable.
REQ-015 instr_out  out  2*WORD_SIZE  fetched instruction.
REQ-016 instr_valid  out  1  instr_out valid.
REQ-017 instr_ready  in  1  consumer accepts instr_out.
REQ-018 instr_error  out  1  invalid-trit flag (only with TRIT_CHECK_EN).

Function
REQ-019 States SHALL be IDLE, WAIT, HOLD, ADVANCE.
REQ-020 IDLE -> WAIT unconditionally on the next cycle.
REQ-021 In WAIT, mem_req = 1 and mem_addr = pc_in; on mem_ready: latch mem_data into instr_out and go to HOLD, or go to ADVANCE with data discarded if a branch is pending.
REQ-022 In HOLD, instr_valid = 1 and instr_out SHALL be stable; on instr_ready go to ADVANCE.
REQ-023 In ADVANCE, pc_update_enable = 1 for exactly one cycle; pc_value = pending branch offset if one is pending, else +1 (trit 0 = +1, all others 0); pending flag cleared; next state WAIT.
REQ-024 A branch_enable seen in any state other than IDLE SHALL record branch_offset as pending; a later branch before ADVANCE overwrites it.
REQ-025 branch_enable in HOLD SHALL drop instr_valid on the next cycle and go to ADVANCE (flush).
REQ-026 branch_enable and instr_ready together in HOLD: handshake completes, ADVANCE uses branch_offset.
REQ-027 pc_update_enable SHALL never be asserted outside ADVANCE; mem_req SHALL be 0 outside WAIT.
REQ-028 PC wrap-around is owned by the PC; the fetcher forwards pc_in unmodified, including -13 after +13 + 1.
REQ-029 Minimum loop latency: 3 cycles per instruction (WAIT with mem_ready, HOLD with instr_ready, ADVANCE).

Reset
REQ-030 reset_enable SHALL force IDLE, clear the pending branch, and zero all outputs on the next edge, in any state, including mid-WAIT (a late mem_ready is ignored).

Configuration
REQ-031 With TRIT_CHECK_EN defined: any 2'b10 trit in mem_data at capture SHALL replace instr_out with all-zero trits (NOP) and pulse instr_error for one cycle; the handshake is otherwise unchanged.
REQ-032 Without TRIT_CHECK_EN: mem_data passes through unchecked, and instr_error SHALL be tied to 0.

Structure
REQ-033 Shared package ternary_pkg SHALL hold the trit encodings, WORD_SIZE, MEM_ADDR_SIZE, and the fetch state encoding.
REQ-034 Invalid-trit detection SHALL be the combinational sub-module trit_word_check.

Verification
REQ-035 Reset, pc_in = 0,0,0, mem_ready after 2 cycles with data = +1 -> instr_valid with instr_out = +1; with instr_ready, one pulse with pc_value = +1.
REQ-036 instr_ready held low 5 cycles in HOLD -> instr_valid = 1, instr_out stable, pc_update_enable = 0 throughout.
REQ-037 branch_enable in HOLD with offset -3 (trit 1 = -1) -> instr_valid drops next cycle, single pulse with pc_value = -3.
REQ-038 branch_enable during WAIT, then mem_ready -> no instr_valid, ADVANCE pc_value = branch offset.
REQ-039 pc_in = 1,1,1 (13), advance by +1 with PC wrap -> next mem_addr = -1,-1,-1 (-13).
REQ-040 mem_data with trit 4 = 2'b10 -> with TRIT_CHECK_EN: instr_out = 0 and instr_error pulses once; without it: raw data passes and instr_error = 0.
